fma_dot_seq: RTL



---
 rtl/fma_pkg.sv | 19 +
 rtl/mac_unit.sv | 20 ++
 rtl/fma_dot_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
// Shared definitions for the dot-product sequencer and its MAC datapath.
//   DEF_WIDTH : default operand width
//   state_t   : sequencer states (ACCUM collects beats, OUTPUT holds a result)
//   acc_width : accumulator width that cannot overflow for a given width/len
package fma_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    // 2*width product bits plus enough headroom for len products and the bias.
    function automatic int acc_width(input int width, input int len);
        return 2 * width + $clog2(len + 1);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational unsigned multiply-add: p = a*b + c_wide.
//   a, b   : WIDTH-bit unsigned operands
//   c_wide : ACC_WIDTH-bit addend (bias on first beat, running sum otherwise)
//   p      : ACC_WIDTH-bit result; ACC_WIDTH > 2*WIDTH so nothing is truncated
module mac_unit #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 11
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [ACC_WIDTH-1:0] c_wide,
    output logic [ACC_WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] prod;

    assign prod = a * b;
    assign p    = {{(ACC_WIDTH - 2*WIDTH){1'b0}}, prod} + c_wide;

endmodule

// File: rtl/fma_dot_seq.sv
// Sequential dot-product engine. Accepts (a, b) beats on a valid/ready input,
// takes bias c with the first beat of each vector, and presents
// c + sum(a_i*b_i) with the beat count on a valid/ready output.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand beat handshake
//   in_a, in_b, in_c     : operands; in_c only sampled on a vector's first beat
//   in_last              : final beat marker (vector also ends at LEN beats)
//   out_valid / out_ready: result handshake
//   out_sum, out_count   : result and number of beats; held after handshake
module fma_dot_seq
    import fma_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN   = 4,
    localparam int CNT_WIDTH = $clog2(LEN + 1),
    localparam int ACC_WIDTH = acc_width(WIDTH, LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_c,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count
);

    state_t                 state, state_nx;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   c_wide;
    logic [ACC_WIDTH-1:0]   mac_p;
    logic                   beat;
    logic                   end_vec;

    assign beat    = in_valid & in_ready;
    // A vector closes on in_last or when the LEN-th beat arrives.
    assign end_vec = in_last | (count == CNT_WIDTH'(LEN - 1));

    // First beat seeds with the bias; acc still holds the previous result
    // there, so it must not be used as the addend.
    assign c_wide = (count == '0) ? {{(ACC_WIDTH - WIDTH){1'b0}}, in_c} : acc;

    mac_unit #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .a      (in_a),
        .b      (in_b),
        .c_wide (c_wide),
        .p      (mac_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (beat && end_vec) state_nx = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ACCUM;
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            count_q <= '0;
            acc     <= '0;
        end else if (beat) begin
            acc <= mac_p;
            if (end_vec) begin
                count_q <= count + CNT_WIDTH'(1);
                count   <= '0;
            end else begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

    assign out_sum   = acc;
    assign out_count = count_q;

endmodule
